// File: rtl/bp_fe_queue_rollback.sv
// FE->BE instruction queue with speculative read, commit (deq) and rewind (roll).
// Three wrap-bit pointers: write, speculative read and commit checkpoint.
module bp_fe_queue_rollback #(
  parameter int els_p   = 8,
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic [width_p-1:0] fe_queue_i,
  input  logic               fe_queue_v_i,
  output logic               fe_queue_ready_o,
  output logic [width_p-1:0] fe_queue_o,
  output logic               fe_queue_v_o,
  input  logic               fe_queue_yumi_i,
  input  logic               fe_queue_deq_i,
  input  logic               fe_queue_roll_i
);

  localparam int idx_w = $clog2(els_p);
  localparam int ptr_w = idx_w + 1;

  logic [width_p-1:0] mem [els_p];

  logic [ptr_w-1:0] wptr, rptr, cptr;
  logic [ptr_w-1:0] wptr_n, rptr_n, cptr_n;

  logic full;
  logic wr;
  logic deq_ok;
  logic yumi_ok;

  // Only committed slots are reusable, so fullness is judged against cptr.
  assign full = (wptr[idx_w-1:0] == cptr[idx_w-1:0])
              & (wptr[ptr_w-1] != cptr[ptr_w-1]);

  assign fe_queue_ready_o = ~full & ~clr_i;
  assign fe_queue_v_o     = (rptr != wptr);
  assign fe_queue_o       = mem[rptr[idx_w-1:0]];

  assign wr      = fe_queue_v_i & fe_queue_ready_o;
  assign deq_ok  = fe_queue_deq_i & (cptr != rptr);
  assign yumi_ok = fe_queue_yumi_i & fe_queue_v_o;

  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    cptr_n = cptr;
    if (clr_i) begin
      wptr_n = '0;
      rptr_n = '0;
      cptr_n = '0;
    end else begin
      if (wr) wptr_n = wptr + 1'b1;
      if (deq_ok) cptr_n = cptr + 1'b1;
      // Rewind lands on the post-deq checkpoint.
      if (fe_queue_roll_i) rptr_n = cptr_n;
      else if (yumi_ok) rptr_n = rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr <= '0;
      rptr <= '0;
      cptr <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr[idx_w-1:0]] <= fe_queue_i;
  end

  a_deq_legal: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (fe_queue_deq_i & ~clr_i) |-> (cptr != rptr)
  );

  a_yumi_legal: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    (fe_queue_yumi_i & ~clr_i & ~fe_queue_roll_i) |-> fe_queue_v_o
  );

endmodule

// File: tb/tb_bp_fe_queue_rollback.sv
// Randomized + directed bench for bp_fe_queue_rollback.
// Reference is a packet queue plus a count of read-but-uncommitted entries.
module tb_bp_fe_queue_rollback;

  localparam int ELS = 8;
  localparam int W   = 128;

  logic         clk = 0;
  logic         reset_n = 0;
  logic         clr = 0;
  logic [W-1:0] din = '0;
  logic         v_i = 0;
  logic         ready;
  logic [W-1:0] dout;
  logic         v_o;
  logic         yumi = 0;
  logic         deq = 0;
  logic         roll = 0;

  bp_fe_queue_rollback #(.els_p(ELS), .width_p(W)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .clr_i            (clr),
    .fe_queue_i       (din),
    .fe_queue_v_i     (v_i),
    .fe_queue_ready_o (ready),
    .fe_queue_o       (dout),
    .fe_queue_v_o     (v_o),
    .fe_queue_yumi_i  (yumi),
    .fe_queue_deq_i   (deq),
    .fe_queue_roll_i  (roll)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // mq: every stored packet, oldest uncommitted first; nrd: how many are read.
  logic [W-1:0] mq[$];
  int           nrd = 0;

  logic         s_rdy, s_v;
  logic [W-1:0] s_d;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic ev;
    ev = (nrd < mq.size());
    chk("ready", W'(ready), W'((mq.size() < ELS) && !clr));
    chk("valid", W'(v_o), W'(ev));
    if (ev) chk("data", dout, mq[nrd]);
  endtask

  task automatic cycle(input bit rst, input bit c, input bit v,
                       input logic [W-1:0] d, input bit y, input bit dq,
                       input bit rl, output logic o_rdy, output logic o_v,
                       output logic [W-1:0] o_d);
    bit fl, vv;
    @(negedge clk);
    reset_n = !rst;
    clr = c; v_i = v; din = d; yumi = y; deq = dq; roll = rl;
    if (rst) begin
      mq.delete();
      nrd = 0;
    end
    #1;
    compare();
    o_rdy = ready; o_v = v_o; o_d = dout;
    @(posedge clk);
    if (!rst) begin
      if (c) begin
        mq.delete();
        nrd = 0;
      end else begin
        fl = (mq.size() >= ELS);
        vv = (nrd < mq.size());
        if (dq && nrd > 0) begin
          void'(mq.pop_front());
          nrd--;
        end
        if (rl) nrd = 0;
        else if (y && vv) nrd++;
        if (v && !fl) mq.push_back(d);
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, '0, 0, 0, 0, s_rdy, s_v, s_d);
  endtask
  task automatic flush();
    cycle(0, 1, 0, '0, 0, 0, 0, s_rdy, s_v, s_d);
  endtask
  task automatic wr(input logic [W-1:0] d);
    cycle(0, 0, 1, d, 0, 0, 0, s_rdy, s_v, s_d);
  endtask
  task automatic rd();
    cycle(0, 0, 0, '0, 1, 0, 0, s_rdy, s_v, s_d);
  endtask
  task automatic fill();
    for (int i = 0; i < 8; i++) wr(W'(8'h10 + i));
  endtask

  initial begin
    // Reset held with random traffic
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
            1'($urandom), 0, 1'($urandom), s_rdy, s_v, s_d);
      chk("rst_valid", W'(s_v), W'(0));
      chk("rst_ready", W'(s_rdy), W'(1));
    end
    wr(W'(8'hA5));
    idle();
    chk("first_data", s_d, W'(8'hA5));
    chk("first_valid", W'(s_v), W'(1));

    // Fill until full, then drain without committing
    flush();
    fill();
    cycle(0, 0, 1, W'(8'h99), 0, 0, 0, s_rdy, s_v, s_d);
    chk("full_ready", W'(s_rdy), W'(0));
    for (int i = 0; i < 8; i++) begin
      rd();
      chk("fill_data", s_d, W'(8'h10 + i));
    end
    idle();
    chk("drained_ready", W'(s_rdy), W'(0));
    chk("drained_valid", W'(s_v), W'(0));
    cycle(0, 0, 0, '0, 0, 1, 0, s_rdy, s_v, s_d);
    idle();
    chk("deq_ready", W'(s_rdy), W'(1));

    // Roll replay
    flush();
    fill();
    for (int i = 0; i < 3; i++) rd();
    cycle(0, 0, 0, '0, 0, 1, 0, s_rdy, s_v, s_d);
    cycle(0, 0, 0, '0, 0, 0, 1, s_rdy, s_v, s_d);
    idle();
    chk("roll_data", s_d, W'(8'h11));
    chk("roll_valid", W'(s_v), W'(1));
    for (int i = 0; i < 7; i++) begin
      rd();
      chk("replay_data", s_d, W'(8'h11 + i));
    end

    // Roll + deq + yumi together
    flush();
    fill();
    for (int i = 0; i < 3; i++) rd();
    cycle(0, 0, 0, '0, 1, 1, 1, s_rdy, s_v, s_d);
    idle();
    chk("rdy_roll_data", s_d, W'(8'h11));

    // Wrap-around stream
    flush();
    for (int i = 0; i < 42; i++) begin
      cycle(0, 0, i < 40, W'(i), i >= 1 && i <= 40, i >= 2, 0,
            s_rdy, s_v, s_d);
      if (i >= 1 && i <= 40) begin
        chk("wrap_data", s_d, W'(i - 1));
        chk("wrap_valid", W'(s_v), W'(1));
      end
    end

    // Flush mid-stream
    flush();
    for (int i = 0; i < 4; i++) wr(W'(8'h30 + i));
    rd();
    cycle(0, 1, 1, W'(8'hFF), 1, 0, 0, s_rdy, s_v, s_d);
    chk("clr_ready_comb", W'(s_rdy), W'(0));
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("clr_valid", W'(s_v), W'(0));
      chk("clr_ready", W'(s_rdy), W'(1));
    end

    // Random traffic with legal-only consume/commit
    for (int i = 0; i < 4000; i++) begin
      bit rst, c, v, y, dq, rl;
      rst = ($urandom % 400 == 0);
      c   = ($urandom % 64 == 0);
      v   = ($urandom % 4 != 0);
      y   = (nrd < mq.size()) && ($urandom % 3 != 0);
      dq  = (nrd > 0) && ($urandom % 2 == 0);
      rl  = ($urandom % 16 == 0);
      cycle(rst, c, v, {$urandom, $urandom, $urandom, $urandom},
            y, dq, rl, s_rdy, s_v, s_d);
    end
    cycle(0, 0, 0, '0, 0, 0, 0, s_rdy, s_v, s_d);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
